// File: rtl/di_key_ctl.sv
// Keyboard control FSM feeding the digital-clock datapath: turns ASCII key
// strobes into digit loads, run/freeze, LED select, alarm arm/disarm and
// alarm ringing. Optional macro DIGIT_RANGE_CHECK_EN limits tens digits to
// 0..5 and ones digits to 0..9; without it any digit 0..9 is accepted.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   rx_data, rx_valid   : received key code and its one-cycle qualifier
//   i_oneSecStrb        : one pulse per second
//   di_i*/di_A*         : live clock digits / stored alarm digits
//   alarm_state         : alarm-armed flag held by the datapath
//   ld*, di_ldA*        : time / alarm digit load strobes
//   ld_num              : digit value for the active load strobe
//   dicRun              : 1 = clock counts, 0 = frozen for entry
//   dicSelectLEDdisp    : LED digit select advance pulse
//   enable_alarm        : write strobe for alarm_state
//   update_alarm        : value written to alarm_state
//   trigger_alarm       : sticky alarm ringing flag
module di_key_ctl #(
  parameter logic [7:0] ESC_CODE   = 8'h1B,
  parameter logic [7:0] ALARM_CODE = 8'h61,
  parameter logic [7:0] LED_CODE   = 8'h6C,
  parameter logic [7:0] ALON_CODE  = 8'h6E,
  parameter logic [7:0] ALOFF_CODE = 8'h66
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       i_oneSecStrb,
  input  logic [3:0] di_iMtens,
  input  logic [3:0] di_iMones,
  input  logic [3:0] di_iStens,
  input  logic [3:0] di_iSones,
  input  logic [3:0] di_AMtens,
  input  logic [3:0] di_AMones,
  input  logic [3:0] di_AStens,
  input  logic [3:0] di_ASones,
  input  logic       alarm_state,
  output logic       ldMtens,
  output logic       ldMones,
  output logic       ldStens,
  output logic       ldSones,
  output logic       di_ldAMtens,
  output logic       di_ldAMones,
  output logic       di_ldAStens,
  output logic       di_ldASones,
  output logic [3:0] ld_num,
  output logic       dicRun,
  output logic       dicSelectLEDdisp,
  output logic       enable_alarm,
  output logic       update_alarm,
  output logic       trigger_alarm
);

  typedef enum logic [3:0] {
    S_RUN,
    S_T_MT,
    S_T_MO,
    S_T_ST,
    S_T_SO,
    S_A_MT,
    S_A_MO,
    S_A_ST,
    S_A_SO
  } state_t;

  // Strobe bit order: time MT,MO,ST,SO then alarm MT,MO,ST,SO.
  localparam logic [7:0] LD_T_MT = 8'b1000_0000;
  localparam logic [7:0] LD_T_MO = 8'b0100_0000;
  localparam logic [7:0] LD_T_ST = 8'b0010_0000;
  localparam logic [7:0] LD_T_SO = 8'b0001_0000;
  localparam logic [7:0] LD_A_MT = 8'b0000_1000;
  localparam logic [7:0] LD_A_MO = 8'b0000_0100;
  localparam logic [7:0] LD_A_ST = 8'b0000_0010;
  localparam logic [7:0] LD_A_SO = 8'b0000_0001;

  state_t     state_q, state_d;
  logic [7:0] ld_q, ld_d;
  logic [3:0] num_q, num_d;
  logic       run_q, run_d;
  logic       led_q, led_d;
  logic       en_q, en_d;
  logic       upd_q, upd_d;
  logic       trig_q, trig_d;

  logic [3:0] dval;
  logic       is_dig;
  logic       tens_ok;
  logic       ones_ok;
  logic       is_esc;
  logic       match;

  assign dval    = rx_data[3:0];
  assign is_dig  = (rx_data[7:4] == 4'h3) && (dval <= 4'd9);
  assign ones_ok = is_dig;
  assign is_esc  = (rx_data == ESC_CODE);

`ifdef DIGIT_RANGE_CHECK_EN
  assign tens_ok = is_dig && (dval <= 4'd5);
`else
  assign tens_ok = is_dig;
`endif

  // Per-state digit acceptance, target strobe and successor state.
  logic       acc;
  logic [7:0] ld_sel;
  state_t     adv;

  always_comb begin
    acc    = 1'b0;
    ld_sel = 8'b0;
    adv    = S_RUN;
    unique case (state_q)
      S_T_MT: begin
        acc    = tens_ok;
        ld_sel = LD_T_MT;
        adv    = S_T_MO;
      end
      S_T_MO: begin
        acc    = ones_ok;
        ld_sel = LD_T_MO;
        adv    = S_T_ST;
      end
      S_T_ST: begin
        acc    = tens_ok;
        ld_sel = LD_T_ST;
        adv    = S_T_SO;
      end
      S_T_SO: begin
        acc    = ones_ok;
        ld_sel = LD_T_SO;
        adv    = S_RUN;
      end
      S_A_MT: begin
        acc    = tens_ok;
        ld_sel = LD_A_MT;
        adv    = S_A_MO;
      end
      S_A_MO: begin
        acc    = ones_ok;
        ld_sel = LD_A_MO;
        adv    = S_A_ST;
      end
      S_A_ST: begin
        acc    = tens_ok;
        ld_sel = LD_A_ST;
        adv    = S_A_SO;
      end
      S_A_SO: begin
        acc    = ones_ok;
        ld_sel = LD_A_SO;
        adv    = S_RUN;
      end
      default: begin
        acc    = 1'b0;
        ld_sel = 8'b0;
        adv    = S_RUN;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    ld_d    = 8'b0;
    num_d   = num_q;
    run_d   = run_q;
    led_d   = 1'b0;
    en_d    = 1'b0;
    upd_d   = upd_q;
    if (rx_valid) begin
      if (state_q == S_RUN) begin
        unique case (1'b1)
          (rx_data == ESC_CODE): begin
            state_d = S_T_MT;
            run_d   = 1'b0;
          end
          (rx_data == ALARM_CODE): begin
            state_d = S_A_MT;
          end
          (rx_data == LED_CODE): begin
            led_d = 1'b1;
          end
          (rx_data == ALON_CODE): begin
            en_d  = 1'b1;
            upd_d = 1'b1;
          end
          (rx_data == ALOFF_CODE): begin
            en_d  = 1'b1;
            upd_d = 1'b0;
          end
          default: begin
            state_d = S_RUN;
          end
        endcase
      end else if (is_esc) begin
        // Abort keeps digits already loaded; just resume counting.
        state_d = S_RUN;
        run_d   = 1'b1;
      end else if (acc) begin
        ld_d    = ld_sel;
        num_d   = dval;
        state_d = adv;
        // Leaving time entry restarts the clock with the last digit.
        if (state_q == S_T_SO) begin
          run_d = 1'b1;
        end
      end
    end
  end

  assign match = alarm_state & run_q &
                 (di_iMtens == di_AMtens) &
                 (di_iMones == di_AMones) &
                 (di_iStens == di_AStens) &
                 (di_iSones == di_ASones);

  // Any key or disarm silences the alarm, and beats a new match.
  always_comb begin
    trig_d = trig_q;
    if (match && i_oneSecStrb) begin
      trig_d = 1'b1;
    end
    if (rx_valid || !alarm_state) begin
      trig_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      ld_q    <= 8'b0;
      num_q   <= 4'd0;
      run_q   <= 1'b1;
      led_q   <= 1'b0;
      en_q    <= 1'b0;
      upd_q   <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      num_q   <= num_d;
      run_q   <= run_d;
      led_q   <= led_d;
      en_q    <= en_d;
      upd_q   <= upd_d;
      trig_q  <= trig_d;
    end
  end

  assign ldMtens          = ld_q[7];
  assign ldMones          = ld_q[6];
  assign ldStens          = ld_q[5];
  assign ldSones          = ld_q[4];
  assign di_ldAMtens      = ld_q[3];
  assign di_ldAMones      = ld_q[2];
  assign di_ldAStens      = ld_q[1];
  assign di_ldASones      = ld_q[0];
  assign ld_num           = num_q;
  assign dicRun           = run_q;
  assign dicSelectLEDdisp = led_q;
  assign enable_alarm     = en_q;
  assign update_alarm     = upd_q;
  assign trigger_alarm    = trig_q;

endmodule

// File: tb/tb_di_key_ctl.sv
// Directed self-checking bench for di_key_ctl.
// Each scenario task drives keys and compares registered outputs inline.
module tb_di_key_ctl;

  localparam logic [7:0] K_ESC = 8'h1B;
  localparam logic [7:0] K_A   = 8'h61;
  localparam logic [7:0] K_L   = 8'h6C;
  localparam logic [7:0] K_N   = 8'h6E;
  localparam logic [7:0] K_F   = 8'h66;
  localparam logic [7:0] K_X   = 8'h78;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       i_oneSecStrb = 1'b0;
  logic [3:0] di_iMtens = 4'd0;
  logic [3:0] di_iMones = 4'd0;
  logic [3:0] di_iStens = 4'd0;
  logic [3:0] di_iSones = 4'd0;
  logic [3:0] di_AMtens = 4'd0;
  logic [3:0] di_AMones = 4'd0;
  logic [3:0] di_AStens = 4'd0;
  logic [3:0] di_ASones = 4'd0;
  logic       alarm_state = 1'b0;
  logic       ldMtens, ldMones, ldStens, ldSones;
  logic       di_ldAMtens, di_ldAMones, di_ldAStens, di_ldASones;
  logic [3:0] ld_num;
  logic       dicRun;
  logic       dicSelectLEDdisp;
  logic       enable_alarm;
  logic       update_alarm;
  logic       trigger_alarm;

  int checks = 0;
  int failures = 0;

  logic [7:0] strb;
  assign strb = {ldMtens, ldMones, ldStens, ldSones,
                 di_ldAMtens, di_ldAMones, di_ldAStens, di_ldASones};

  always #5 clk = ~clk;

  di_key_ctl dut (
    .clk              (clk),
    .rst              (rst),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .i_oneSecStrb     (i_oneSecStrb),
    .di_iMtens        (di_iMtens),
    .di_iMones        (di_iMones),
    .di_iStens        (di_iStens),
    .di_iSones        (di_iSones),
    .di_AMtens        (di_AMtens),
    .di_AMones        (di_AMones),
    .di_AStens        (di_AStens),
    .di_ASones        (di_ASones),
    .alarm_state      (alarm_state),
    .ldMtens          (ldMtens),
    .ldMones          (ldMones),
    .ldStens          (ldStens),
    .ldSones          (ldSones),
    .di_ldAMtens      (di_ldAMtens),
    .di_ldAMones      (di_ldAMones),
    .di_ldAStens      (di_ldAStens),
    .di_ldASones      (di_ldASones),
    .ld_num           (ld_num),
    .dicRun           (dicRun),
    .dicSelectLEDdisp (dicSelectLEDdisp),
    .enable_alarm     (enable_alarm),
    .update_alarm     (update_alarm),
    .trigger_alarm    (trigger_alarm)
  );

  task automatic send_key(input logic [7:0] k, input logic sec);
    @(negedge clk);
    rx_data      = k;
    rx_valid     = 1'b1;
    i_oneSecStrb = sec;
    @(posedge clk);
    #1;
    rx_valid     = 1'b0;
    i_oneSecStrb = 1'b0;
  endtask

  task automatic pulse_sec();
    @(negedge clk);
    i_oneSecStrb = 1'b1;
    @(posedge clk);
    #1;
    i_oneSecStrb = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    checks++;
    if ({dicRun, strb, ld_num, trigger_alarm, dicSelectLEDdisp,
         enable_alarm, update_alarm} !== {1'b1, 8'h00, 4'd0, 4'b0000}) begin
      failures++;
      $display("FAIL reset: run=%b strb=%b num=%0d trig=%b led=%b en=%b upd=%b want run=1 rest 0",
               dicRun, strb, ld_num, trigger_alarm, dicSelectLEDdisp,
               enable_alarm, update_alarm);
    end
  endtask

  task automatic test_time_entry();
    send_key(K_ESC, 1'b0);
    checks++;
    if (dicRun !== 1'b0 || strb !== 8'h00) begin
      failures++;
      $display("FAIL esc_freeze: run=%b strb=%b want 0/00", dicRun, strb);
    end
    send_key(8'h31, 1'b0);
    checks++;
    if (strb !== 8'h80 || ld_num !== 4'd1 || dicRun !== 1'b0) begin
      failures++;
      $display("FAIL t_mt: strb=%b num=%0d run=%b want 10000000/1/0",
               strb, ld_num, dicRun);
    end
    send_key(8'h32, 1'b0);
    checks++;
    if (strb !== 8'h40 || ld_num !== 4'd2) begin
      failures++;
      $display("FAIL t_mo: strb=%b num=%0d want 01000000/2", strb, ld_num);
    end
    send_key(8'h33, 1'b0);
    checks++;
    if (strb !== 8'h20 || ld_num !== 4'd3) begin
      failures++;
      $display("FAIL t_st: strb=%b num=%0d want 00100000/3", strb, ld_num);
    end
    send_key(8'h34, 1'b0);
    checks++;
    if (strb !== 8'h10 || ld_num !== 4'd4 || dicRun !== 1'b1) begin
      failures++;
      $display("FAIL t_so: strb=%b num=%0d run=%b want 00010000/4/1",
               strb, ld_num, dicRun);
    end
    idle(1);
    checks++;
    if (strb !== 8'h00 || ld_num !== 4'd4 || dicRun !== 1'b1) begin
      failures++;
      $display("FAIL t_hold: strb=%b num=%0d run=%b want 0/4/1",
               strb, ld_num, dicRun);
    end
    // Back in RUN: a digit must be ignored.
    send_key(8'h35, 1'b0);
    checks++;
    if (strb !== 8'h00 || ld_num !== 4'd4) begin
      failures++;
      $display("FAIL run_digit: strb=%b num=%0d want 0/4", strb, ld_num);
    end
  endtask

  task automatic test_range();
    send_key(K_ESC, 1'b0);
    send_key(8'h37, 1'b0);
`ifdef DIGIT_RANGE_CHECK_EN
    checks++;
    if (strb !== 8'h00 || ld_num !== 4'd4) begin
      failures++;
      $display("FAIL range_reject: strb=%b num=%0d want 0/4", strb, ld_num);
    end
    send_key(8'h32, 1'b0);
    checks++;
    if (strb !== 8'h80 || ld_num !== 4'd2) begin
      failures++;
      $display("FAIL range_next: strb=%b num=%0d want 10000000/2",
               strb, ld_num);
    end
`else
    checks++;
    if (strb !== 8'h80 || ld_num !== 4'd7) begin
      failures++;
      $display("FAIL range_accept: strb=%b num=%0d want 10000000/7",
               strb, ld_num);
    end
    send_key(8'h32, 1'b0);
    checks++;
    if (strb !== 8'h40 || ld_num !== 4'd2) begin
      failures++;
      $display("FAIL range_next: strb=%b num=%0d want 01000000/2",
               strb, ld_num);
    end
`endif
    // Non-digit key in entry is ignored, then ESC aborts.
    send_key(K_X, 1'b0);
    checks++;
    if (strb !== 8'h00 || dicRun !== 1'b0) begin
      failures++;
      $display("FAIL entry_other: strb=%b run=%b want 0/0", strb, dicRun);
    end
    send_key(K_ESC, 1'b0);
    checks++;
    if (dicRun !== 1'b1 || strb !== 8'h00) begin
      failures++;
      $display("FAIL range_abort: run=%b strb=%b want 1/0", dicRun, strb);
    end
  endtask

  task automatic test_alarm_entry();
    send_key(K_A, 1'b0);
    checks++;
    if (dicRun !== 1'b1 || strb !== 8'h00) begin
      failures++;
      $display("FAIL a_start: run=%b strb=%b want 1/0", dicRun, strb);
    end
    send_key(8'h30, 1'b0);
    checks++;
    if (strb !== 8'h08 || ld_num !== 4'd0) begin
      failures++;
      $display("FAIL a_mt: strb=%b num=%0d want 00001000/0", strb, ld_num);
    end
    send_key(8'h31, 1'b0);
    checks++;
    if (strb !== 8'h04 || ld_num !== 4'd1) begin
      failures++;
      $display("FAIL a_mo: strb=%b num=%0d want 00000100/1", strb, ld_num);
    end
    send_key(8'h30, 1'b0);
    checks++;
    if (strb !== 8'h02 || ld_num !== 4'd0) begin
      failures++;
      $display("FAIL a_st: strb=%b num=%0d want 00000010/0", strb, ld_num);
    end
    send_key(8'h30, 1'b0);
    checks++;
    if (strb !== 8'h01 || ld_num !== 4'd0 || dicRun !== 1'b1) begin
      failures++;
      $display("FAIL a_so: strb=%b num=%0d run=%b want 00000001/0/1",
               strb, ld_num, dicRun);
    end
    send_key(K_N, 1'b0);
    checks++;
    if (enable_alarm !== 1'b1 || update_alarm !== 1'b1) begin
      failures++;
      $display("FAIL al_on: en=%b upd=%b want 1/1", enable_alarm, update_alarm);
    end
    idle(1);
    checks++;
    if (enable_alarm !== 1'b0 || update_alarm !== 1'b1) begin
      failures++;
      $display("FAIL al_on_end: en=%b upd=%b want 0/1",
               enable_alarm, update_alarm);
    end
    send_key(K_F, 1'b0);
    checks++;
    if (enable_alarm !== 1'b1 || update_alarm !== 1'b0) begin
      failures++;
      $display("FAIL al_off: en=%b upd=%b want 1/0", enable_alarm, update_alarm);
    end
    send_key(K_L, 1'b0);
    checks++;
    if (dicSelectLEDdisp !== 1'b1 || enable_alarm !== 1'b0) begin
      failures++;
      $display("FAIL led: led=%b en=%b want 1/0", dicSelectLEDdisp, enable_alarm);
    end
    idle(1);
    checks++;
    if (dicSelectLEDdisp !== 1'b0) begin
      failures++;
      $display("FAIL led_end: led=%b want 0", dicSelectLEDdisp);
    end
  endtask

  task automatic test_abort();
    send_key(K_ESC, 1'b0);
    send_key(8'h33, 1'b0);
    checks++;
    if (strb !== 8'h80 || ld_num !== 4'd3) begin
      failures++;
      $display("FAIL abort_mt: strb=%b num=%0d want 10000000/3", strb, ld_num);
    end
    send_key(K_ESC, 1'b0);
    checks++;
    if (dicRun !== 1'b1 || strb !== 8'h00) begin
      failures++;
      $display("FAIL abort: run=%b strb=%b want 1/0", dicRun, strb);
    end
    send_key(8'h31, 1'b0);
    checks++;
    if (strb !== 8'h00 || ld_num !== 4'd3) begin
      failures++;
      $display("FAIL abort_run: strb=%b num=%0d want 0/3", strb, ld_num);
    end
  endtask

  task automatic test_alarm_match();
    @(negedge clk);
    alarm_state = 1'b1;
    {di_AMtens, di_AMones, di_AStens, di_ASones} = 16'h0100;
    {di_iMtens, di_iMones, di_iStens, di_iSones} = 16'h0101;
    pulse_sec();
    checks++;
    if (trigger_alarm !== 1'b0) begin
      failures++;
      $display("FAIL trig_nomatch: trig=%b want 0", trigger_alarm);
    end
    @(negedge clk);
    di_iSones = 4'd0;
    idle(1);
    checks++;
    if (trigger_alarm !== 1'b0) begin
      failures++;
      $display("FAIL trig_nostrb: trig=%b want 0", trigger_alarm);
    end
    pulse_sec();
    checks++;
    if (trigger_alarm !== 1'b1) begin
      failures++;
      $display("FAIL trig_set: trig=%b want 1", trigger_alarm);
    end
    @(negedge clk);
    di_iSones = 4'd1;
    idle(2);
    checks++;
    if (trigger_alarm !== 1'b1) begin
      failures++;
      $display("FAIL trig_sticky: trig=%b want 1", trigger_alarm);
    end
    send_key(K_X, 1'b0);
    checks++;
    if (trigger_alarm !== 1'b0) begin
      failures++;
      $display("FAIL trig_key_clr: trig=%b want 0", trigger_alarm);
    end
    @(negedge clk);
    di_iSones = 4'd0;
    pulse_sec();
    @(negedge clk);
    alarm_state = 1'b0;
    i_oneSecStrb = 1'b1;
    idle(1);
    i_oneSecStrb = 1'b0;
    checks++;
    if (trigger_alarm !== 1'b0) begin
      failures++;
      $display("FAIL trig_disarm: trig=%b want 0", trigger_alarm);
    end
    @(negedge clk);
    alarm_state = 1'b1;
    send_key(K_X, 1'b1);
    checks++;
    if (trigger_alarm !== 1'b0) begin
      failures++;
      $display("FAIL trig_clr_wins: trig=%b want 0", trigger_alarm);
    end
    send_key(K_ESC, 1'b0);
    pulse_sec();
    checks++;
    if (trigger_alarm !== 1'b0 || dicRun !== 1'b0) begin
      failures++;
      $display("FAIL trig_frozen: trig=%b run=%b want 0/0",
               trigger_alarm, dicRun);
    end
    send_key(K_ESC, 1'b0);
    pulse_sec();
    checks++;
    if (trigger_alarm !== 1'b1) begin
      failures++;
      $display("FAIL trig_resume: trig=%b want 1", trigger_alarm);
    end
    @(negedge clk);
    alarm_state = 1'b0;
    idle(1);
  endtask

  task automatic test_reset_mid_entry();
    send_key(K_ESC, 1'b0);
    send_key(8'h31, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (dicRun !== 1'b1 || ld_num !== 4'd0 || strb !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid: run=%b num=%0d strb=%b want 1/0/0",
               dicRun, ld_num, strb);
    end
    send_key(8'h32, 1'b0);
    checks++;
    if (strb !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid_run: strb=%b want 0", strb);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_time_entry();
    test_range();
    test_alarm_entry();
    test_abort();
    test_alarm_match();
    test_reset_mid_entry();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
